// File: rtl/nmx_rram_array_ctrl.sv
// ReRAM array controller: ROWS x COLS cell array behind a posted-write queue,
// with counter-timed reads, read-after-write forwarding and queue status flags.
module nmx_rram_array_ctrl #(
  parameter int unsigned ROWS    = 32,
  parameter int unsigned COLS    = 32,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned RD_DLY  = 44,
  parameter int unsigned WR_DLY  = 10,
  parameter int unsigned RD_HOLD = 1,
  localparam int unsigned AW     = $clog2(ROWS) + $clog2(COLS),
  localparam int unsigned PW     = $clog2(DEPTH)
) (
  input  logic              CLKin,
  input  logic              RSTin,
  input  logic              EN,
  input  logic              R_WB,
  input  logic [AW-1:0]     AD,
  input  logic [DATA_W-1:0] DI,
  output logic [DATA_W-1:0] DO,
  output logic              func_ack,
  output logic              busy,
  output logic              full,
  output logic              empty,
  output logic [PW:0]       pend_cnt,
  output logic              ovf
);

  localparam int unsigned CW  = $clog2(COLS);
  localparam int unsigned TW  = $clog2(WR_DLY + 1);
  localparam int unsigned RCW = $clog2(((RD_DLY > RD_HOLD) ? RD_DLY : RD_HOLD) + 1);

  localparam logic [TW-1:0]  WrReload   = TW'(WR_DLY - 1);
  localparam logic [RCW-1:0] RdReload   = RCW'(RD_DLY - 1);
  localparam logic [RCW-1:0] HoldReload = RCW'(RD_HOLD - 1);
  localparam logic [PW:0]    DepthCnt   = (PW + 1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StRdWait, StRdHold} state_e;

  state_e             state_q, state_d;
  logic [RCW-1:0]     rd_cnt_q, rd_cnt_d;
  logic [DATA_W-1:0]  snap_q, snap_d;
  logic [DATA_W-1:0]  do_q, do_d;
  logic               ack_q, ack_d;
  logic               ovf_q, ovf_d;
  logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [PW:0]        cnt_q;
  logic [TW-1:0]      drain_q, drain_d;

  logic [AW-1:0]      q_addr_q [DEPTH];
  logic [DATA_W-1:0]  q_data_q [DEPTH];
  logic [DATA_W-1:0]  mem_q    [ROWS][COLS];

  logic               q_full, q_empty;
  logic               wr_req, rd_req, push, commit, rd_done;
  logic [AW-1:0]      head_addr;
  logic [DATA_W-1:0]  fwd_data;
  logic [PW-1:0]      fwd_idx;

  // Fullness is judged on the registered count; a same-cycle commit never frees a slot.
  assign q_full    = (cnt_q == DepthCnt);
  assign q_empty   = (cnt_q == '0);
  assign wr_req    = (state_q == StIdle) && EN && !R_WB;
  assign rd_req    = (state_q == StIdle) && EN && R_WB;
  assign push      = wr_req && !q_full;
  assign commit    = !q_empty && (drain_q == '0);
  assign head_addr = q_addr_q[rd_ptr_q];

  // Drain timer idles at its reload value so a push into an empty queue starts a full period.
  always_comb begin
    drain_d = drain_q;
    if (q_empty || commit) begin
      drain_d = WrReload;
    end else begin
      drain_d = drain_q - TW'(1);
    end
  end

  // Walk the queue oldest to youngest so the youngest matching entry wins.
  always_comb begin
    fwd_data = mem_q[AD[AW-1:CW]][AD[CW-1:0]];
    fwd_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = rd_ptr_q + PW'(i);
      if (((PW + 1)'(i) < cnt_q) && (q_addr_q[fwd_idx] == AD)) begin
        fwd_data = q_data_q[fwd_idx];
      end
    end
  end

  always_ff @(posedge CLKin or negedge RSTin) begin
    if (!RSTin) begin
      state_q  <= StIdle;
      rd_cnt_q <= '0;
      snap_q   <= '0;
      do_q     <= '0;
      ack_q    <= 1'b0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      drain_q  <= WrReload;
    end else begin
      state_q  <= state_d;
      rd_cnt_q <= rd_cnt_d;
      snap_q   <= snap_d;
      do_q     <= do_d;
      ack_q    <= ack_d;
      ovf_q    <= ovf_d;
      drain_q  <= drain_d;
      cnt_q    <= cnt_q + (PW + 1)'(push) - (PW + 1)'(commit);
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (commit) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

  // Queue payload and the cell array carry no reset: contents survive RSTin.
  always_ff @(posedge CLKin) begin
    if (push) begin
      q_addr_q[wr_ptr_q] <= AD;
      q_data_q[wr_ptr_q] <= DI;
    end
    if (commit) begin
      mem_q[head_addr[AW-1:CW]][head_addr[CW-1:0]] <= q_data_q[rd_ptr_q];
    end
  end

  always_comb begin
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    snap_d   = snap_q;
    unique case (state_q)
      StIdle: begin
        if (rd_req) begin
          state_d  = StRdWait;
          rd_cnt_d = RdReload;
          snap_d   = fwd_data;
        end
      end
      StRdWait: begin
        if (!EN) begin
          state_d = StIdle;
        end else if (rd_cnt_q == '0) begin
          state_d  = StRdHold;
          rd_cnt_d = HoldReload;
        end else begin
          rd_cnt_d = rd_cnt_q - RCW'(1);
        end
      end
      StRdHold: begin
        if (rd_cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          rd_cnt_d = rd_cnt_q - RCW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rd_done  = (state_q == StRdWait) && EN && (rd_cnt_q == '0);
    ack_d    = push || rd_done || ((state_q == StRdHold) && (rd_cnt_q != '0));
    do_d     = rd_done ? snap_q : do_q;
    ovf_d    = wr_req && q_full;
    busy     = (state_q != StIdle);
    full     = q_full;
    empty    = q_empty;
    pend_cnt = cnt_q;
    DO       = do_q;
    func_ack = ack_q;
    ovf      = ovf_q;
  end

endmodule

// File: tb/tb_nmx_rram_array_ctrl.sv
// Bench for nmx_rram_array_ctrl: directed scenarios plus a randomized mix, all checked
// against a queue-of-writes model with per-entry commit times.
module tb_nmx_rram_array_ctrl;

  localparam int unsigned ROWS    = 32;
  localparam int unsigned COLS    = 32;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned RD_DLY  = 44;
  localparam int unsigned WR_DLY  = 10;
  localparam int unsigned RD_HOLD = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic       r_wb = 1'b0;
  logic [9:0] ad = '0;
  logic [7:0] di = '0;
  logic [7:0] dout;
  logic       func_ack, busy, full, empty, ovf;
  logic [3:0] pend_cnt;

  always #5 clk = ~clk;

  nmx_rram_array_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .DEPTH(DEPTH),
    .RD_DLY(RD_DLY), .WR_DLY(WR_DLY), .RD_HOLD(RD_HOLD)
  ) dut (
    .CLKin(clk), .RSTin(rst_n), .EN(en), .R_WB(r_wb), .AD(ad), .DI(di), .DO(dout),
    .func_ack(func_ack), .busy(busy), .full(full), .empty(empty), .pend_cnt(pend_cnt),
    .ovf(ovf)
  );

  typedef struct {
    logic [9:0]  a;
    logic [7:0]  d;
    int unsigned c;
  } ent_t;

  ent_t        pq[$];
  logic [7:0]  mem_m [1024];
  bit          known [1024];
  logic [7:0]  last_do = '0;
  int unsigned cyc = 0;
  int          vectors = 0;
  int          errors = 0;

  // One clock edge; writes whose commit time has arrived land in the model array.
  task automatic tick();
    @(posedge clk);
    cyc++;
    while (pq.size() > 0 && pq[0].c == cyc) begin
      mem_m[pq[0].a] = pq[0].d;
      known[pq[0].a] = 1'b1;
      void'(pq.pop_front());
    end
    #1;
  endtask

  function automatic logic [16:0] model_stat(bit ack, bit bsy, bit ov, logic [7:0] d);
    logic [3:0] n;
    n = 4'(pq.size());
    return {ack, bsy, n == 4'(DEPTH), n == 4'd0, ov, n, d};
  endfunction

  function automatic logic [7:0] model_read(logic [9:0] a);
    logic [7:0] v;
    v = mem_m[a];
    foreach (pq[i]) if (pq[i].a == a) v = pq[i].d;
    return v;
  endfunction

  function automatic bit model_known(logic [9:0] a);
    bit k;
    k = known[a];
    foreach (pq[i]) if (pq[i].a == a) k = 1'b1;
    return k;
  endfunction

  task automatic idle(int n, string name);
    logic [16:0] exp;
    en   = 1'b0;
    r_wb = 1'b0;
    for (int k = 0; k < n; k++) begin
      tick();
      exp = model_stat(1'b0, 1'b0, 1'b0, last_do);
      vectors++;
      if ({func_ack, busy, full, empty, ovf, pend_cnt, dout} !== exp) begin
        errors++;
        $display("FAIL %s cyc=%0d {ack,busy,full,empty,ovf,pend,DO} got=%b want=%b", name, cyc,
                 {func_ack, busy, full, empty, ovf, pend_cnt, dout}, exp);
      end
    end
  endtask

  task automatic drive_write(logic [9:0] a, logic [7:0] d, string name);
    bit          acc;
    int unsigned base;
    logic [16:0] exp;
    en   = 1'b1;
    r_wb = 1'b0;
    ad   = a;
    di   = d;
    acc  = pq.size() < DEPTH;
    tick();
    if (acc) begin
      base = (pq.size() > 0) ? pq[$].c : cyc;
      pq.push_back('{a, d, base + WR_DLY});
    end
    exp = model_stat(acc, 1'b0, !acc, last_do);
    vectors++;
    if ({func_ack, busy, full, empty, ovf, pend_cnt, dout} !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d {ack,busy,full,empty,ovf,pend,DO} got=%b want=%b", name, cyc,
               {func_ack, busy, full, empty, ovf, pend_cnt, dout}, exp);
    end
  endtask

  // abort_at = 0 runs the read to completion; otherwise EN drops before edge N+abort_at.
  task automatic drive_read(logic [9:0] a, int abort_at, string name);
    logic [7:0]  want;
    logic [16:0] exp;
    want = model_read(a);
    en   = 1'b1;
    r_wb = 1'b1;
    ad   = a;
    tick();
    exp = model_stat(1'b0, 1'b1, 1'b0, last_do);
    vectors++;
    if ({func_ack, busy, full, empty, ovf, pend_cnt, dout} !== exp) begin
      errors++;
      $display("FAIL %s accept cyc=%0d got=%b want=%b", name, cyc,
               {func_ack, busy, full, empty, ovf, pend_cnt, dout}, exp);
    end
    // A write request presented while the read is in flight must be ignored.
    r_wb = 1'b0;
    di   = 8'($urandom);
    for (int j = 1; j < RD_DLY; j++) begin
      if (abort_at == j) begin
        en = 1'b0;
        tick();
        exp = model_stat(1'b0, 1'b0, 1'b0, last_do);
        vectors++;
        if ({func_ack, busy, full, empty, ovf, pend_cnt, dout} !== exp) begin
          errors++;
          $display("FAIL %s abort cyc=%0d got=%b want=%b", name, cyc,
                   {func_ack, busy, full, empty, ovf, pend_cnt, dout}, exp);
        end
        return;
      end
      tick();
      exp = model_stat(1'b0, 1'b1, 1'b0, last_do);
      vectors++;
      if ({func_ack, busy, full, empty, ovf, pend_cnt, dout} !== exp) begin
        errors++;
        $display("FAIL %s wait cyc=%0d got=%b want=%b", name, cyc,
                 {func_ack, busy, full, empty, ovf, pend_cnt, dout}, exp);
      end
    end
    tick();
    last_do = want;
    exp = model_stat(1'b1, 1'b1, 1'b0, last_do);
    vectors++;
    if ({func_ack, busy, full, empty, ovf, pend_cnt, dout} !== exp) begin
      errors++;
      $display("FAIL %s data cyc=%0d got=%b want=%b", name, cyc,
               {func_ack, busy, full, empty, ovf, pend_cnt, dout}, exp);
    end
    en = 1'b0;
    for (int h = 1; h < RD_HOLD; h++) begin
      tick();
      exp = model_stat(1'b1, 1'b1, 1'b0, last_do);
      vectors++;
      if ({func_ack, busy, full, empty, ovf, pend_cnt, dout} !== exp) begin
        errors++;
        $display("FAIL %s hold cyc=%0d got=%b want=%b", name, cyc,
                 {func_ack, busy, full, empty, ovf, pend_cnt, dout}, exp);
      end
    end
    tick();
    exp = model_stat(1'b0, 1'b0, 1'b0, last_do);
    vectors++;
    if ({func_ack, busy, full, empty, ovf, pend_cnt, dout} !== exp) begin
      errors++;
      $display("FAIL %s release cyc=%0d got=%b want=%b", name, cyc,
               {func_ack, busy, full, empty, ovf, pend_cnt, dout}, exp);
    end
  endtask

  task automatic test_reset();
    #2;
    rst_n = 1'b0;
    tick();
    tick();
    vectors++;
    if ({func_ack, busy, full, empty, ovf, pend_cnt, dout} !== 17'b0_0_0_1_0_0000_00000000) begin
      errors++;
      $display("FAIL reset_values got=%b want=%b", {func_ack, busy, full, empty, ovf, pend_cnt,
               dout}, 17'b0_0_0_1_0_0000_00000000);
    end
    rst_n = 1'b1;
    idle(2, "post_reset");
  endtask

  task automatic test_single_write();
    drive_write(10'h021, 8'hA5, "write_021");
    idle(12, "drain_021");
  endtask

  task automatic test_read_after_commit();
    drive_read(10'h021, 0, "read_021");
    vectors++;
    if (dout !== 8'hA5) begin
      errors++;
      $display("FAIL read_021_value got=%h want=a5", dout);
    end
  endtask

  task automatic test_forwarding();
    drive_write(10'h3FF, 8'h5A, "write_3ff");
    drive_read(10'h3FF, 0, "fwd_read_5a");
    vectors++;
    if (dout !== 8'h5A) begin
      errors++;
      $display("FAIL fwd_5a_value got=%h want=5a", dout);
    end
    drive_write(10'h3FF, 8'h11, "write_3ff_11");
    drive_write(10'h3FF, 8'h22, "write_3ff_22");
    drive_read(10'h3FF, 0, "fwd_read_22");
    vectors++;
    if (dout !== 8'h22) begin
      errors++;
      $display("FAIL fwd_youngest_value got=%h want=22", dout);
    end
    idle(2 * WR_DLY + 2, "fwd_drain");
  endtask

  task automatic test_back_to_back();
    idle(WR_DLY * DEPTH + 2, "b2b_pre");
    for (int i = 0; i <= DEPTH; i++) begin
      drive_write(10'h040 + 10'(i), 8'($urandom), "b2b_write");
      if (i == DEPTH - 1) begin
        vectors++;
        if (full !== 1'b1) begin
          errors++;
          $display("FAIL b2b_full got=%b want=1", full);
        end
      end
      if (i == DEPTH) begin
        vectors++;
        if ({ovf, func_ack} !== 2'b10) begin
          errors++;
          $display("FAIL b2b_overflow {ovf,ack} got=%b want=10", {ovf, func_ack});
        end
      end
    end
    idle(WR_DLY * DEPTH + 2, "b2b_drain");
    vectors++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL b2b_empty got=%b want=1", empty);
    end
  endtask

  task automatic test_read_abort();
    drive_read(10'h021, 20, "abort_read");
    drive_write(10'h0AA, 8'($urandom), "write_after_abort");
    vectors++;
    if (func_ack !== 1'b1) begin
      errors++;
      $display("FAIL abort_next_write_ack got=%b want=1", func_ack);
    end
    idle(WR_DLY + 2, "abort_drain");
  endtask

  task automatic test_reset_mid_read();
    drive_write(10'h021, 8'h77, "pend_021");
    drive_write(10'h100, 8'h33, "pend_100");
    drive_write(10'h200, 8'h44, "pend_200");
    en   = 1'b1;
    r_wb = 1'b1;
    ad   = 10'h100;
    for (int k = 0; k < 6; k++) tick();
    rst_n = 1'b0;
    pq.delete();
    last_do = '0;
    #1;
    vectors++;
    if ({func_ack, busy, full, empty, ovf, pend_cnt, dout} !== model_stat(0, 0, 0, 8'h00)) begin
      errors++;
      $display("FAIL mid_read_reset got=%b want=%b", {func_ack, busy, full, empty, ovf,
               pend_cnt, dout}, model_stat(0, 0, 0, 8'h00));
    end
    en = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    idle(3, "after_mid_reset");
    drive_read(10'h021, 0, "read_after_reset");
    vectors++;
    if (dout !== 8'hA5) begin
      errors++;
      $display("FAIL array_survives_reset got=%h want=a5", dout);
    end
  endtask

  task automatic test_random();
    logic [9:0] pool [4];
    logic [9:0] a;
    pool[0] = 10'h021;
    pool[1] = 10'h3FF;
    pool[2] = 10'h155;
    pool[3] = 10'h2AA;
    for (int it = 0; it < 40; it++) begin
      a = pool[$urandom_range(0, 3)];
      if ($urandom_range(0, 3) == 0 && model_known(a)) begin
        if ($urandom_range(0, 3) == 0) drive_read(a, int'($urandom_range(1, RD_DLY - 1)), "rnd_abort");
        else drive_read(a, 0, "rnd_read");
      end else begin
        drive_write(a, 8'($urandom), "rnd_write");
      end
      idle(int'($urandom_range(0, 2)), "rnd_idle");
    end
    idle(WR_DLY * DEPTH + 5, "rnd_drain");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_write();
    test_read_after_commit();
    test_forwarding();
    test_back_to_back();
    test_read_abort();
    test_reset_mid_read();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
